// File: rtl/tb_lifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lifo
//  Description : Two-bank ping-pong LIFO for a Viterbi traceback stage. Bits
//                arrive in reverse time order in bursts (blocks). Each closed
//                block is read out last-in-first-out, which restores forward
//                time order, over a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lifo #(
    parameter int DEPTH = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_en,
    input  logic d_in,
    output logic d_out,
    output logic d_valid,
    input  logic d_ready,
    output logic d_last,
    output logic overflow,
    output logic busy
);

    localparam int                c_AW       = $clog2(DEPTH);
    localparam logic [c_AW-1:0]   c_WLAST    = c_AW'(DEPTH - 1);
    localparam logic [c_AW:0]     c_FULL_LEN = (c_AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DEPTH-1:0]  r_mem [2];
    logic [1:0]        r_full;
    logic [c_AW:0]     r_len [2];
    logic [c_AW-1:0]   r_wptr;
    logic [c_AW-1:0]   r_rptr;
    logic              r_wb;
    logic              r_rb;
    logic              r_overflow;

    logic              w_wr_acc;
    logic              w_wr_drop;
    logic              w_close;
    logic [c_AW:0]     w_close_len;
    logic              w_start;
    logic              w_xfer;
    logic              w_done;
    logic [c_AW-1:0]   w_rptr_load;

    // Full flags are the registered values, so a bank freed on this edge
    // still rejects the write landing on the same edge.
    assign w_wr_acc  = wr_en & ~r_full[r_wb];
    assign w_wr_drop = wr_en &  r_full[r_wb];

    // A burst closes when the strobe drops with data pending, or when the
    // last slot of the bank is written.
    assign w_close     = (w_wr_acc && (r_wptr == c_WLAST)) || (!wr_en && (r_wptr != '0));
    assign w_close_len = w_wr_acc ? c_FULL_LEN : {1'b0, r_wptr};

    assign w_start = (r_state == S_IDLE) && r_full[r_rb];
    assign w_xfer  = (r_state == S_READ) && d_ready;
    assign w_done  = w_xfer && (r_rptr == '0);

    // Start address is length-1; a full-depth block (MSB set) starts at the top.
    assign w_rptr_load = r_len[r_rb][c_AW] ? c_WLAST
                                           : (r_len[r_rb][c_AW-1:0] - c_AW'(1));

    // Bank storage: no reset needed, contents are qualified by full flags.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wb][r_wptr] <= d_in;
        end
    end

    // Write pointer, write bank select and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_wb       <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_close) begin
                r_wptr <= '0;
                r_wb   <= ~r_wb;
            end else if (w_wr_acc) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Per-bank full flags and block lengths: set at close, cleared on last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full   <= 2'b00;
            r_len[0] <= '0;
            r_len[1] <= '0;
        end else begin
            if (w_close) begin
                r_full[r_wb] <= 1'b1;
                r_len[r_wb]  <= w_close_len;
            end
            if (w_done) begin
                r_full[r_rb] <= 1'b0;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read FSM next-state: the return to IDLE after the last beat gives a
    // one-cycle bubble between consecutive blocks.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_full[r_rb]) w_state_nxt = S_READ;
            S_READ:  if (w_done)       w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // Read pointer walks down from length-1; read bank toggles per block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr <= '0;
            r_rb   <= 1'b0;
        end else begin
            if (w_start) begin
                r_rptr <= w_rptr_load;
            end else if (w_xfer && (r_rptr != '0)) begin
                r_rptr <= r_rptr - c_AW'(1);
            end
            if (w_done) begin
                r_rb <= ~r_rb;
            end
        end
    end

    assign d_valid  = (r_state == S_READ);
    assign d_out    = d_valid & r_mem[r_rb][r_rptr];
    assign d_last   = d_valid & (r_rptr == '0);
    assign overflow = r_overflow;
    assign busy     = (|r_full) | (r_wptr != '0);

endmodule
`default_nettype wire

// File: tb/tb_tb_lifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tb_lifo
//  Description : Self-checking bench for tb_lifo. A queue-based model of the
//                two-bank block buffer predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tb_lifo;

    localparam int c_DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    logic wr_en;
    logic d_in;
    logic d_out;
    logic d_valid;
    logic d_ready;
    logic d_last;
    logic overflow;
    logic busy;

    int checks = 0;
    int fails  = 0;

    tb_lifo #(.DEPTH(c_DEPTH)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .d_in     (d_in),
        .d_out    (d_out),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_last   (d_last),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [c_DEPTH-1:0] bits;
        int                 len;
    } blk_t;

    blk_t       blocks[$];   // closed blocks in close order (at most two)
    logic       open_q[$];   // burst being collected
    bit         m_reading;
    int         m_pos;
    bit         m_ovf;
    logic [1:0] got[$];      // observed beats {d_out, d_last}

    task automatic model_reset();
        blocks.delete();
        open_q.delete();
        m_reading = 1'b0;
        m_pos     = 0;
        m_ovf     = 1'b0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        int   n;
        bit   pop;
        bit   close;
        blk_t b;
        n     = blocks.size();
        pop   = 1'b0;
        close = 1'b0;
        if (m_reading) begin
            if (d_ready) begin
                if (m_pos == 0) begin
                    pop       = 1'b1;
                    m_reading = 1'b0;
                end else begin
                    m_pos--;
                end
            end
        end else if (n > 0) begin
            m_reading = 1'b1;
            m_pos     = blocks[0].len - 1;
        end
        if (wr_en) begin
            if (n == 2) begin
                m_ovf = 1'b1;
            end else begin
                open_q.push_back(d_in);
                if (open_q.size() == c_DEPTH) close = 1'b1;
            end
        end else if (open_q.size() > 0) begin
            close = 1'b1;
        end
        if (pop) void'(blocks.pop_front());
        if (close) begin
            b.bits = '0;
            b.len  = open_q.size();
            for (int i = 0; i < b.len; i++) b.bits[i] = open_q[i];
            blocks.push_back(b);
            open_q.delete();
        end
    endtask

    // {d_valid, d_out, d_last, busy, overflow} predicted by the model.
    function automatic logic [4:0] exp_vec();
        logic o;
        o = m_reading ? blocks[0].bits[m_pos] : 1'b0;
        return {m_reading, o, m_reading && (m_pos == 0),
                (blocks.size() > 0) || (open_q.size() > 0), m_ovf};
    endfunction

    function automatic logic [4:0] obs();
        return {d_valid, d_out, d_last, busy, overflow};
    endfunction

    // One clock cycle of stimulus; records beats that transfer on the edge.
    task automatic tick(input logic w, input logic d, input logic r);
        wr_en   = w;
        d_in    = d;
        d_ready = r;
        if (d_valid && d_ready) got.push_back({d_out, d_last});
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; d_in = 1'b0; d_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 5'b00000) begin
            fails++;
            $display("FAIL reset_state: got %b expected 00000", obs());
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reversal();
        logic [7:0] seq;
        seq = 8'b1000_1011;               // seq[i] is the i-th bit written
        got.delete();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, seq[i], 1'b1);
            checks++;
            if (obs() !== exp_vec()) begin
                fails++; $display("FAIL reversal_cyc: got %b expected %b", obs(), exp_vec());
            end
        end
        tick(1'b0, 1'b0, 1'b1);           // close edge
        checks++;
        if (d_valid !== 1'b0) begin
            fails++; $display("FAIL reversal_latency_close: d_valid got %b expected 0", d_valid);
        end
        tick(1'b0, 1'b0, 1'b1);           // IDLE saw full -> READ
        checks++;
        if (d_valid !== 1'b1) begin
            fails++; $display("FAIL reversal_latency_rise: d_valid got %b expected 1", d_valid);
        end
        for (int c = 0; c < 40 && (m_reading || blocks.size() > 0); c++) begin
            tick(1'b0, 1'b0, 1'b1);
            checks++;
            if (obs() !== exp_vec()) begin
                fails++; $display("FAIL reversal_drain: got %b expected %b", obs(), exp_vec());
            end
        end
        checks++;
        if (got.size() != 8) begin
            fails++; $display("FAIL reversal_count: got %0d beats expected 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== {seq[7-i], (i == 7) ? 1'b1 : 1'b0}) begin
                    fails++;
                    $display("FAIL reversal_beat%0d: got %b expected %b", i, got[i], {seq[7-i], (i == 7)});
                end
            end
        end
    endtask

    task automatic test_ping_pong();
        logic [68:0] pat;
        int          bubbles;
        int          k;
        for (int i = 0; i < 69; i++) pat[i] = 1'($urandom);
        got.delete();
        bubbles = 0;
        for (int c = 0; c < 400; c++) begin
            if (c < 69) tick(1'b1, pat[c], 1'b1);
            else        tick(1'b0, 1'b0, 1'b1);
            checks++;
            if (obs() !== exp_vec()) begin
                fails++; $display("FAIL pingpong_cyc%0d: got %b expected %b", c, obs(), exp_vec());
            end
            if (got.size() > 0 && got.size() < 69 && !d_valid) bubbles++;
            if (c >= 69 && !m_reading && blocks.size() == 0) break;
        end
        checks++;
        if (bubbles != 1 || overflow !== 1'b0) begin
            fails++; $display("FAIL pingpong_bubble_ovf: bubbles %0d ovf %b expected 1 and 0", bubbles, overflow);
        end
        checks++;
        if (got.size() != 69) begin
            fails++; $display("FAIL pingpong_count: got %0d beats expected 69", got.size());
        end else begin
            for (int i = 0; i < 69; i++) begin
                k = (i < 64) ? (63 - i) : (64 + 68 - i);
                checks++;
                if (got[i] !== {pat[k], (i == 63 || i == 68) ? 1'b1 : 1'b0}) begin
                    fails++; $display("FAIL pingpong_beat%0d: got %b expected %b", i, got[i], {pat[k], (i == 63 || i == 68)});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] seq;
        logic [1:0] hold;
        bit         seen;
        seq = 6'($urandom);
        got.delete();
        for (int i = 0; i < 6; i++) tick(1'b1, seq[i], 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick(1'b0, 1'b0, 1'b0);
            seen = d_valid;
        end
        checks++;
        if (!seen) begin
            fails++; $display("FAIL bp_wait_valid: d_valid got 0 expected 1 within 10 cycles");
        end
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        hold = {d_out, d_last};
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if ({d_valid, d_out, d_last} !== {1'b1, hold} || obs() !== exp_vec()) begin
                fails++; $display("FAIL bp_stall%0d: got %b expected %b", c, obs(), exp_vec());
            end
        end
        for (int c = 0; c < 20 && (m_reading || blocks.size() > 0); c++) begin
            tick(1'b0, 1'b0, 1'b1);
            checks++;
            if (obs() !== exp_vec()) begin
                fails++; $display("FAIL bp_drain: got %b expected %b", obs(), exp_vec());
            end
        end
        checks++;
        if (got.size() != 6) begin
            fails++; $display("FAIL bp_count: got %0d beats expected 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got[i] !== {seq[5-i], (i == 5) ? 1'b1 : 1'b0}) begin
                    fails++; $display("FAIL bp_beat%0d: got %b expected %b", i, got[i], {seq[5-i], (i == 5)});
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [8:0] pat;
        pat = 9'($urandom);
        got.delete();
        for (int blk = 0; blk < 3; blk++) begin
            if (blk == 2) begin
                checks++;
                if (overflow !== 1'b0) begin
                    fails++; $display("FAIL ovf_before: got %b expected 0", overflow);
                end
            end
            for (int i = 0; i < 3; i++) begin
                tick(1'b1, pat[blk*3+i], 1'b0);
                checks++;
                if (obs() !== exp_vec()) begin
                    fails++; $display("FAIL ovf_fill: got %b expected %b", obs(), exp_vec());
                end
            end
            tick(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_set: got %b expected 1", overflow);
        end
        for (int c = 0; c < 30 && (m_reading || blocks.size() > 0); c++) begin
            tick(1'b0, 1'b0, 1'b1);
            checks++;
            if (obs() !== exp_vec()) begin
                fails++; $display("FAIL ovf_drain: got %b expected %b", obs(), exp_vec());
            end
        end
        checks++;
        if (got.size() != 6 || overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_count_sticky: beats %0d ovf %b expected 6 and 1", got.size(), overflow);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got[i] !== {pat[(i < 3) ? (2 - i) : (8 - i)], (i == 2 || i == 5) ? 1'b1 : 1'b0}) begin
                    fails++; $display("FAIL ovf_beat%0d: got %b", i, got[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        got.delete();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom), 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 20 && got.size() < 2; c++) tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (d_valid !== 1'b1 || got.size() != 2) begin
            fails++; $display("FAIL rstmid_pre: d_valid %b beats %0d expected 1 and 2", d_valid, got.size());
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({d_valid, busy, overflow} !== 3'b000) begin
            fails++; $display("FAIL rstmid_async: got %b expected 000", {d_valid, busy, overflow});
        end
        #2;
        rst = 1'b0;
        model_reset();
        got.delete();
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 10 && (m_reading || blocks.size() > 0); c++) begin
            tick(1'b0, 1'b0, 1'b1);
            checks++;
            if (obs() !== exp_vec()) begin
                fails++; $display("FAIL rstmid_drain: got %b expected %b", obs(), exp_vec());
            end
        end
        checks++;
        if (got.size() != 2 || got[0] !== 2'b00 || got[1] !== 2'b11) begin
            fails++; $display("FAIL rstmid_fresh: beats %0d got %p expected 00,11", got.size(), got);
        end
    endtask

    task automatic test_single_bit();
        got.delete();
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 10 && (m_reading || blocks.size() > 0); c++) begin
            tick(1'b0, 1'b0, 1'b1);
            checks++;
            if (obs() !== exp_vec()) begin
                fails++; $display("FAIL single_cyc: got %b expected %b", obs(), exp_vec());
            end
        end
        checks++;
        if (got.size() != 1 || got[0] !== 2'b11) begin
            fails++; $display("FAIL single_beat: beats %0d got %p expected 11", got.size(), got);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom_range(0, 2) != 0));
            checks++;
            if (obs() !== exp_vec()) begin
                fails++; $display("FAIL random_cyc%0d: got %b expected %b", c, obs(), exp_vec());
            end
        end
        for (int c = 0; c < 300 && (m_reading || blocks.size() > 0 || open_q.size() > 0); c++) begin
            tick(1'b0, 1'b0, 1'b1);
            checks++;
            if (obs() !== exp_vec()) begin
                fails++; $display("FAIL random_drain: got %b expected %b", obs(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_reversal();
        test_ping_pong();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_single_bit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tb_lifo.md
TB_LIFO -- requirements
Module: tb_lifo

Interface
REQ-001 Parameter: DEPTH, default 64, maximum bits per traceback block and per bank (power of two, at least 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 wr_en  input  1  traceback write strobe: d_in is valid this cycle.
REQ-005 d_in  input  1  decoded bit from the traceback stage, in reverse time order.
REQ-006 d_out  output  1  decoded bit, restored to forward time order.
REQ-007 d_valid  output  1  d_out is valid.
REQ-008 d_ready  input  1  consumer accepts d_out.
REQ-009 d_last  output  1  final bit of a block; qualified by d_valid.
REQ-010 overflow  output  1  sticky flag: an input bit was dropped.
REQ-011 busy  output  1  at least one bank is full or a write burst is open.

Function
REQ-012 The block SHALL hold two banks (0 and 1). Each bank SHALL have DEPTH 1-bit entries, a full flag and a length register of log2(DEPTH)+1 bits.
REQ-013 Write side: on each edge with wr_en=1 and the write bank not full, the block SHALL store d_in at wptr and increment wptr.
REQ-014 Burst close SHALL occur on the edge where either:
- wr_en=0 is sampled with wptr>0, or
- the DEPTH-th bit is written.
REQ-015 At burst close the block SHALL, on that edge: set the bank full flag, set length=count, reset wptr to 0, and toggle the write bank. If wr_en stays high after DEPTH bits, the next bit SHALL go to the other bank.
REQ-016 A write strobe targeting a full bank SHALL drop the bit, leave wptr unchanged and set overflow. Full flags are evaluated as registered at the start of the cycle.
REQ-017 Read FSM states: IDLE and READ.
- IDLE -> READ when the read bank full flag=1; rptr loads length-1.
- In READ: d_valid=1 and d_out=bank[rb][rptr].
REQ-018 Handshake: a beat transfers on an edge with d_valid=1 and d_ready=1. d_out and d_last SHALL stay stable while d_valid=1 and d_ready=0.
REQ-019 On a transfer with rptr>0, rptr SHALL decrement.
REQ-020 On a transfer with rptr=0, d_last SHALL be 1 on that beat. The read bank full flag SHALL clear, rb SHALL toggle, and the FSM SHALL return to IDLE, giving one bubble cycle between blocks.
REQ-021 Latency: d_valid SHALL first rise 2 cycles after the close edge (close edge -> IDLE sees full -> READ).
REQ-022 If a write hits the bank being freed in the same cycle, the bit SHALL be dropped and overflow set; the freed bank accepts writes from the next cycle.
REQ-023 Block order SHALL be preserved: banks are read in the order they closed.
REQ-024 busy SHALL be 1 when either full flag=1 or wptr>0.
REQ-025 A block of length 1 SHALL output a single beat with d_last=1.

Reset
REQ-026 While rst=1, asynchronously: full flags=0, wptr=0, rptr=0, wb=0, rb=0, FSM=IDLE, d_valid=0, d_last=0, d_out=0, overflow=0, busy=0.
REQ-027 Bank contents need no reset.
REQ-028 Reset mid-burst or mid-read SHALL discard all partial and buffered data.
REQ-029 The first write after rst deasserts SHALL go to bank 0, address 0.

Verification
REQ-030 Basic reversal: write 8 bits 1,1,0,1,0,0,0,1 (wr_en high 8 cycles), then wr_en=0, d_ready=1 -> d_out 1,0,0,0,1,0,1,1. d_valid rises 2 cycles after the close edge; d_last=1 on the 8th beat only.
REQ-031 Full-depth ping-pong: write 64+5 bits continuously with DEPTH=64 -> bank 0 closes at the 64th bit and the next 5 go to bank 1. Output is block A reversed (64 beats), one bubble, then block B reversed (5 beats); overflow=0.
REQ-032 Backpressure: during a read, hold d_ready=0 for 4 cycles -> d_out and d_last are stable and no beat is lost or duplicated.
REQ-033 Overflow: d_ready=0, fill both banks with 3-bit blocks, then write a third block -> those bits are dropped and overflow=1 (sticky). After draining, blocks 1 and 2 come out intact.
REQ-034 Reset mid-operation: assert rst during the 3rd output beat -> d_valid=0, busy=0 and overflow=0 immediately. A fresh 2-bit block 1,0 then outputs 0,1.
REQ-035 Single-bit block: wr_en high for 1 cycle with d_in=1 -> one beat with d_out=1 and d_last=1.
